cpu_stream_loader: RTL and testbench

CPU_STREAM_LOADER -- requirements
Module: cpu_stream_loader

---
 rtl/cpu_stream_loader_pkg.sv | 21 ++
 rtl/cpu_stream_loader_if.sv | 23 ++
 rtl/cpu_stream_loader_word_assembler.sv | 47 ++++
 rtl/cpu_stream_loader.sv | 131 +++++++++++++
 tb/tb_cpu_stream_loader.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_stream_loader_pkg.sv
// Shared constants for the UART program loader: command marker, command codes
// and the controller state encoding.
package cpu_stream_loader_pkg;

  localparam logic [7:0] CMD_MARK      = 8'hFF;
  localparam logic [7:0] CMD_START     = 8'h00;
  localparam logic [7:0] CMD_END_RESET = 8'hFF;
  localparam logic [7:0] CMD_END_KEEP  = 8'hF0;
  localparam logic [7:0] CMD_SET_ADDR  = 8'h0A;
  localparam logic [7:0] CMD_CHECK     = 8'hCC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_DECODE,
    ST_WRITE,
    ST_WAIT_PC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cpu_stream_loader_if.sv
// Byte-stream handshake from the UART plus the instruction-RAM write bus.
interface cpu_stream_loader_if #(
  parameter int WORD_BYTES = 3,
  parameter int ADDR_W     = 8
) ();
  logic                    packet_ready;
  logic [7:0]              packet_data;
  logic                    packet_ack;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [8*WORD_BYTES-1:0] mem_wdata;
  logic                    mem_ack;

  modport master (
    input  packet_ready, packet_data, mem_ack,
    output packet_ack, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output packet_ready, packet_data, mem_ack,
    input  packet_ack, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_stream_loader_word_assembler.sv
// Four-phase byte handshake and little-endian word assembly; pulses
// word_valid for one cycle once WORD_BYTES bytes have been captured.
module loader_word_assembler #(
  parameter int WORD_BYTES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept,
  input  logic                    packet_ready,
  input  logic [7:0]              packet_data,
  output logic                    packet_ack,
  output logic                    word_valid,
  output logic                    partial,
  output logic [8*WORD_BYTES-1:0] word
);
  localparam int CNT_W = $clog2(WORD_BYTES + 1);

  logic [CNT_W-1:0] byte_cnt;
  logic             take;

  // A byte is taken only on the rising phase, so each one is captured once.
  assign take    = accept && packet_ready && !packet_ack;
  assign partial = (byte_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      packet_ack <= 1'b0;
      word_valid <= 1'b0;
      byte_cnt   <= '0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (take) begin
        packet_ack <= 1'b1;
        word       <= {packet_data, word[8*WORD_BYTES-1:8]};
        if (byte_cnt == CNT_W'(WORD_BYTES - 1)) begin
          byte_cnt   <= '0;
          word_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end else if (packet_ack && !packet_ready) begin
        packet_ack <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/cpu_stream_loader.sv
// Loads a program over a UART byte stream into instruction RAM while the CPU
// is halted; decodes in-band commands, tracks a running byte checksum.
module cpu_stream_loader
  import cpu_stream_loader_pkg::*;
#(
  parameter int WORD_BYTES = 3,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt_flag,
  input  logic [ADDR_W-1:0]   pc_addr,
  cpu_stream_loader_if.master bus,
  output logic                cpu_paused,
  output logic                reset_pc,
  output logic                load_done,
  output logic                checksum_err,
  output logic [ADDR_W:0]     word_count
);
  localparam int WORD_W = 8 * WORD_BYTES;

  state_t            state, next_state;
  logic              accept, word_valid, partial, active;
  logic [WORD_W-1:0] word, word_p0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        checksum, code;
  logic              is_cmd, start_ok;

  function automatic logic [7:0] byte_sum(input logic [WORD_W-1:0] w);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < WORD_BYTES; i++) s = s + w[8*i +: 8];
    return s;
  endfunction

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return c[ADDR_W] ? c : c + (ADDR_W + 1)'(1);
  endfunction

  loader_word_assembler #(.WORD_BYTES(WORD_BYTES)) u_asm (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .packet_ready(bus.packet_ready),
    .packet_data (bus.packet_data),
    .packet_ack  (bus.packet_ack),
    .word_valid  (word_valid),
    .partial     (partial),
    .word        (word)
  );

  assign is_cmd   = (word_p0[WORD_W-1 -: 8] == CMD_MARK);
  assign code     = word_p0[WORD_W-9 -: 8];
  assign start_ok = (state == ST_DECODE) && is_cmd && (code == CMD_START) &&
                    halt_flag && !active;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_RECV: begin
        if (word_valid)   next_state = ST_DECODE;
        else if (partial) next_state = ST_RECV;
        else              next_state = ST_IDLE;
      end
      ST_DECODE: begin
        next_state = ST_IDLE;
        if (active && !is_cmd)                            next_state = ST_WRITE;
        else if (active && is_cmd && code == CMD_END_RESET) next_state = ST_WAIT_PC;
        else if (active && is_cmd && code == CMD_END_KEEP)  next_state = ST_DONE;
      end
      ST_WRITE:   if (bus.mem_ack) next_state = ST_IDLE;
      ST_WAIT_PC: if (pc_addr == '0) next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == ST_IDLE) || (state == ST_RECV);
    reset_pc  = (state == ST_WAIT_PC);
    load_done = (state == ST_DONE);
  end

  assign bus.mem_we    = (state == ST_WRITE);
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = word_p0;

  // Decode / write stage: word_p0 holds the word being acted on.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_p0      <= '0;
      active       <= 1'b0;
      cpu_paused   <= 1'b0;
      mem_addr     <= '0;
      word_count   <= '0;
      checksum     <= '0;
      checksum_err <= 1'b0;
    end else begin
      if (accept && word_valid) word_p0 <= word;
      if (state == ST_DECODE && active && is_cmd) begin
        if (code == CMD_SET_ADDR) mem_addr <= word_p0[ADDR_W-1:0];
        if (code == CMD_CHECK) begin
          if (checksum != word_p0[7:0]) checksum_err <= 1'b1;
          checksum <= '0;
        end
      end
      if (start_ok) begin
        active       <= 1'b1;
        cpu_paused   <= 1'b1;
        mem_addr     <= '0;
        word_count   <= '0;
        checksum     <= '0;
        checksum_err <= 1'b0;
      end
      if (state == ST_WRITE && bus.mem_ack) begin
        mem_addr   <= mem_addr + ADDR_W'(1);
        word_count <= sat_inc(word_count);
        checksum   <= checksum + byte_sum(word_p0);
      end
      if (next_state == ST_DONE && state != ST_DONE) begin
        active     <= 1'b0;
        cpu_paused <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cpu_stream_loader.sv
// Directed bench for cpu_stream_loader (WORD_BYTES=3, ADDR_W=8) with a
// one-cycle-latency RAM responder.
module tb_cpu_stream_loader;
  localparam int WORD_BYTES = 3;
  localparam int ADDR_W     = 8;
  localparam int LIMIT      = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              halt_flag = 1'b1;
  logic [ADDR_W-1:0] pc_addr = 8'h05;
  logic              cpu_paused, reset_pc, load_done, checksum_err;
  logic [ADDR_W:0]   word_count;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_rpc  = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [23:0]       wr_data[$];

  cpu_stream_loader_if #(.WORD_BYTES(WORD_BYTES), .ADDR_W(ADDR_W)) bus ();

  cpu_stream_loader #(.WORD_BYTES(WORD_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_flag   (halt_flag),
    .pc_addr     (pc_addr),
    .bus         (bus),
    .cpu_paused  (cpu_paused),
    .reset_pc    (reset_pc),
    .load_done   (load_done),
    .checksum_err(checksum_err),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bus.mem_ack = bus.mem_we;
  end

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1 && bus.mem_ack === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (load_done === 1'b1) n_done++;
    if (reset_pc === 1'b1) n_rpc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.packet_data  = b;
    bus.packet_ready = 1'b1;
    n = 0;
    while (bus.packet_ack !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    chk("ack_rise_in_time", 32'(n < LIMIT), 32'd1);
    bus.packet_ready = 1'b0;
    n = 0;
    while (bus.packet_ack !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
    chk("ack_fall_in_time", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 0; i < WORD_BYTES; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    int d0, r0;
    bus.packet_ready = 1'b0;
    bus.packet_data  = 8'h00;
    bus.mem_ack      = 1'b0;
    idle(3);
    chk("rst_cpu_paused", 32'(cpu_paused), 32'd0);
    chk("rst_reset_pc", 32'(reset_pc), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_packet_ack", 32'(bus.packet_ack), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_checksum_err", 32'(checksum_err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    idle(2);

    // Basic load ending with END_KEEP
    d0 = n_done; r0 = n_rpc;
    wr_addr.delete(); wr_data.delete();
    send_word(24'hFF0000);
    idle(2);
    chk("start_paused", 32'(cpu_paused), 32'd1);
    send_word(24'h123456);
    send_word(24'hABCDEF);
    send_word(24'hFFF000);
    idle(4);
    chk("basic_nwrites", 32'(wr_addr.size()), 32'd2);
    chk("basic_addr0", 32'(wr_addr[0]), 32'h00);
    chk("basic_data0", 32'(wr_data[0]), 32'h123456);
    chk("basic_addr1", 32'(wr_addr[1]), 32'h01);
    chk("basic_data1", 32'(wr_data[1]), 32'hABCDEF);
    chk("basic_word_count", 32'(word_count), 32'd2);
    chk("basic_done_pulses", 32'(n_done - d0), 32'd1);
    chk("basic_no_reset_pc", 32'(n_rpc - r0), 32'd0);
    chk("basic_unpaused", 32'(cpu_paused), 32'd0);

    // START refused while CPU running; data with no load discarded
    halt_flag = 1'b0;
    wr_addr.delete(); wr_data.delete();
    send_word(24'hFF0000);
    send_word(24'h000001);
    idle(6);
    chk("nohalt_paused", 32'(cpu_paused), 32'd0);
    chk("nohalt_nwrites", 32'(wr_addr.size()), 32'd0);
    halt_flag = 1'b1;

    // END_RESET waits for pc_addr==0
    d0 = n_done;
    send_word(24'hFF0000);
    send_word(24'hFFFF00);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      chk("wait_reset_pc", 32'(reset_pc), 32'd1);
      chk("wait_paused", 32'(cpu_paused), 32'd1);
      idle(1);
    end
    pc_addr = 8'h00;
    idle(1);
    chk("pc0_reset_pc", 32'(reset_pc), 32'd0);
    chk("pc0_paused", 32'(cpu_paused), 32'd0);
    chk("pc0_load_done", 32'(load_done), 32'd1);
    idle(1);
    chk("pc0_done_once", 32'(n_done - d0), 32'd1);
    pc_addr = 8'h05;

    // SET_ADDR near the top of memory, address wrap
    wr_addr.delete(); wr_data.delete();
    send_word(24'hFF0000);
    send_word(24'hFF0AFE);
    send_word(24'h000011);
    send_word(24'h000022);
    send_word(24'h000033);
    send_word(24'hFFF000);
    idle(4);
    chk("wrap_nwrites", 32'(wr_addr.size()), 32'd3);
    chk("wrap_addr0", 32'(wr_addr[0]), 32'hFE);
    chk("wrap_addr1", 32'(wr_addr[1]), 32'hFF);
    chk("wrap_addr2", 32'(wr_addr[2]), 32'h00);
    chk("wrap_data2", 32'(wr_data[2]), 32'h000033);
    chk("wrap_word_count", 32'(word_count), 32'd3);

    // Checksum mismatch, sticky, cleared by next START, then a match
    send_word(24'hFF0000);
    send_word(24'h010203);
    send_word(24'hFFCC05);
    idle(2);
    chk("cks_mismatch", 32'(checksum_err), 32'd1);
    send_word(24'hFFF000);
    idle(3);
    chk("cks_sticky", 32'(checksum_err), 32'd1);
    send_word(24'hFF0000);
    idle(2);
    chk("cks_cleared_by_start", 32'(checksum_err), 32'd0);
    send_word(24'h020202);
    send_word(24'hFFCC06);
    idle(2);
    chk("cks_match", 32'(checksum_err), 32'd0);
    send_word(24'hFFF000);
    idle(3);

    // Reset mid-load with a partial word pending
    send_word(24'hFF0000);
    idle(2);
    chk("midrst_paused_before", 32'(cpu_paused), 32'd1);
    send_byte(8'h77);
    send_byte(8'h88);
    rst = 1'b1;
    idle(1);
    chk("midrst_paused_drop", 32'(cpu_paused), 32'd0);
    chk("midrst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    idle(1);
    wr_addr.delete(); wr_data.delete();
    send_word(24'hFF0000);
    idle(2);
    chk("midrst_start_ok", 32'(cpu_paused), 32'd1);
    send_word(24'h0000AA);
    send_word(24'hFFF000);
    idle(4);
    chk("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
    chk("midrst_addr0", 32'(wr_addr[0]), 32'h00);
    chk("midrst_data0", 32'(wr_data[0]), 32'h0000AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
